tx_framer: RTL
==============

TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 SHALL have parameter SKP_INTERVAL, default 64: clk_1m cycles between SKP ordered-set requests.
REQ-002 SHALL have ports in this order: clk_1m in 1, single clock, all logic on rising edge; reset in 1, synchronous, active-high.
REQ-003 SHALL have data_in in 8: payload byte from upstream.
REQ-004 SHALL have valid_in in 1: data_in valid.
REQ-005 SHALL have last_in in 1: data_in is the final packet byte.
REQ-006 SHALL have dllp_in in 1: sampled at packet start; 1 selects SDP, 0 selects STP.
REQ-007 SHALL have ready_out out 1: byte accepted on a cycle with valid_in & ready_out.
REQ-008 SHALL have data_out out 8: line byte, registered.
REQ-009 SHALL have k_out out 1: 1 marks data_out as a control symbol.
REQ-010 SHALL have underrun_err out 1: one-cycle pulse on a mid-packet gap.

Function
REQ-011 SHALL use symbols COM=8'hBC, SKP=8'h1C, STP=8'hFB, SDP=8'h5C, END=8'hFD, IDL=8'h7C; every symbol SHALL be emitted with k_out=1 and payload with k_out=0.
REQ-012 SHALL implement states IDLE, START, DATA, ENDS, SKP_COM, SKP_1, SKP_2, SKP_3, emitting one byte per cycle.
REQ-013 IDLE SHALL emit IDL and go to SKP_COM if skp_pending, else to START if valid_in, else stay in IDLE; ready_out=0.
REQ-014 START SHALL emit STP or SDP per the dllp_in value latched on the IDLE->START transition, then go to DATA; ready_out=0.
REQ-015 DATA SHALL drive ready_out=1; on valid_in it SHALL emit data_in with k_out=0 on the next cycle, going to ENDS if last_in and otherwise staying in DATA.
REQ-016 DATA with valid_in=0 SHALL emit IDL (k_out=1), pulse underrun_err for one cycle and stay in DATA.
REQ-017 ENDS SHALL emit END, then go to SKP_COM if skp_pending, else START if valid_in, else IDLE.
REQ-018 SKP_COM, SKP_1, SKP_2 and SKP_3 SHALL emit COM, SKP, SKP, SKP in sequence; SKP_3 SHALL go to START if valid_in, else IDLE; ready_out=0 throughout.
REQ-019 An output SHALL appear one cycle after its state or accepted byte (registered, latency 1).
REQ-020 The SKP counter SHALL count every cycle from 0 and, at SKP_INTERVAL-1, SHALL set skp_pending and wrap to 0.
REQ-021 skp_pending SHALL clear on entry to SKP_COM; further expirations while pending SHALL not queue a second ordered set.
REQ-022 An ordered set SHALL never interrupt a packet: expiry during START or DATA SHALL defer insertion until after END.
REQ-023 When skp_pending and valid_in coincide in IDLE or ENDS, the SKP ordered set SHALL take priority.
REQ-024 A single-byte packet (valid_in & last_in on the first DATA beat) SHALL produce STP/SDP, byte, END.
REQ-025 dllp_in SHALL be ignored outside the IDLE/ENDS/SKP_3->START transition.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL set state=IDLE, data_out=8'h7C, k_out=1, ready_out=0, underrun_err=0, SKP counter=0 and skp_pending=0.
REQ-027 Reset mid-packet SHALL discard the packet without emitting END; IDL SHALL be emitted the cycle after reset.

Structure
REQ-028 Symbol constants and state encodings SHALL reside in a shared package/include used by tx_framer and the existing demux.
REQ-029 The SKP counter and pending flag SHALL be one sub-module, skp_timer, parameterised by SKP_INTERVAL.

Verification
REQ-030 Idle line test: reset for 2 cycles then release with valid_in=0 -> data_out=8'h7C, k_out=1 every cycle until the first SKP ordered set.
REQ-031 TLP test: send bytes 8'h11, 8'h22, 8'h33 (last on 8'h33) with dllp_in=0 -> FB(k), 11, 22, 33, FD(k), then 7C.
REQ-032 DLLP single-byte test: send 8'hA5 with last_in=1 and dllp_in=1 -> 5C(k), A5, FD(k).
REQ-033 SKP timing test: SKP_INTERVAL=8 with an idle line -> BC,1C,1C,1C (all k) every 8 cycles; an expiry mid-packet -> the set follows FD, never splits payload.
REQ-034 Underrun test: drop valid_in for 1 cycle mid-packet -> one 7C(k), one underrun_err pulse, then the remaining bytes and FD.
REQ-035 Reset test: assert reset during the DATA byte 8'h22 -> next output 7C(k), no FD, ready_out=0.

Source files
------------

// File: rtl/tx_framer_pkg.sv
// Shared line-coding symbols and framer state encoding, used by tx_framer and
// by the receive-side demux.
package tx_framer_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] SYM_COM = 8'hBC;
  localparam logic [DATA_W-1:0] SYM_SKP = 8'h1C;
  localparam logic [DATA_W-1:0] SYM_STP = 8'hFB;
  localparam logic [DATA_W-1:0] SYM_SDP = 8'h5C;
  localparam logic [DATA_W-1:0] SYM_END = 8'hFD;
  localparam logic [DATA_W-1:0] SYM_IDL = 8'h7C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_ENDS,
    ST_SKP_COM,
    ST_SKP_1,
    ST_SKP_2,
    ST_SKP_3
  } state_t;

endpackage

// File: rtl/tx_framer_skp_timer.sv
// Free-running SKP interval counter with a single-entry pending flag.
module skp_timer #(
  parameter int SKP_INTERVAL = 64
) (
  input  logic clk_1m,
  input  logic reset,
  input  logic skp_take,
  output logic skp_pending
);

  localparam int CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SKP_INTERVAL - 1);

  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = (cnt == CNT_MAX);

  // An expiry landing on the same edge as the take re-arms the flag, so that
  // interval is not lost; otherwise expiries while pending simply merge.
  always_ff @(posedge clk_1m) begin
    if (reset) begin
      cnt         <= '0;
      skp_pending <= 1'b0;
    end else begin
      cnt <= expire ? '0 : cnt + 1'b1;
      if (expire)
        skp_pending <= 1'b1;
      else if (skp_take)
        skp_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_framer.sv
// Packet framer: wraps upstream bytes in STP/SDP ... END, fills gaps with IDL
// and inserts COM,SKP,SKP,SKP ordered sets between packets.
module tx_framer
  import tx_framer_pkg::*;
#(
  parameter int SKP_INTERVAL = 64
) (
  input  logic       clk_1m,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       last_in,
  input  logic       dllp_in,
  output logic       ready_out,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic       underrun_err
);

  state_t      state, state_nxt;
  logic        dllp_q, dllp_nxt;
  logic [7:0]  data_nxt;
  logic        k_nxt;
  logic        underrun_nxt;
  logic        skp_pending;
  logic        skp_take;

  skp_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp_timer (
    .clk_1m      (clk_1m),
    .reset       (reset),
    .skp_take    (skp_take),
    .skp_pending (skp_pending)
  );

  assign ready_out = (state == ST_DATA);
  assign skp_take  = (state_nxt == ST_SKP_COM);

  always_comb begin
    state_nxt    = state;
    dllp_nxt     = dllp_q;
    data_nxt     = SYM_IDL;
    k_nxt        = 1'b1;
    underrun_nxt = 1'b0;
    case (state)
      ST_IDLE, ST_ENDS: begin
        data_nxt = (state == ST_ENDS) ? SYM_END : SYM_IDL;
        if (skp_pending) begin
          state_nxt = ST_SKP_COM;
        end else if (valid_in) begin
          state_nxt = ST_START;
          dllp_nxt  = dllp_in;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        data_nxt  = dllp_q ? SYM_SDP : SYM_STP;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (valid_in) begin
          data_nxt = data_in;
          k_nxt    = 1'b0;
          if (last_in)
            state_nxt = ST_ENDS;
        end else begin
          underrun_nxt = 1'b1;
        end
      end
      ST_SKP_COM: begin
        data_nxt  = SYM_COM;
        state_nxt = ST_SKP_1;
      end
      ST_SKP_1: begin
        data_nxt  = SYM_SKP;
        state_nxt = ST_SKP_2;
      end
      ST_SKP_2: begin
        data_nxt  = SYM_SKP;
        state_nxt = ST_SKP_3;
      end
      ST_SKP_3: begin
        data_nxt = SYM_SKP;
        if (valid_in) begin
          state_nxt = ST_START;
          dllp_nxt  = dllp_in;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output stage: line byte and flags registered one cycle after the state.
  always_ff @(posedge clk_1m) begin
    if (reset) begin
      state        <= ST_IDLE;
      dllp_q       <= 1'b0;
      data_out     <= SYM_IDL;
      k_out        <= 1'b1;
      underrun_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      dllp_q       <= dllp_nxt;
      data_out     <= data_nxt;
      k_out        <= k_nxt;
      underrun_err <= underrun_nxt;
    end
  end

endmodule
